control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; opcode values and state encodings are fixed in the shared package.
REQ-002 Clock  in  1  single clock; all state changes on the rising edge.
REQ-003 clr  in  1  reset; asynchronous, active-low.
REQ-004 IR  in  32  instruction register contents; opcode in IR[31:27].
REQ-005 CON  in  1  branch condition flag from the condition flip-flop.
REQ-006 Stop  in  1  halt request, sampled only at instruction boundaries.
REQ-007 Run  out  1  high while executing; low in HALT.
REQ-008 HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin  out  1 each  register load enables.
REQ-009 HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout  out  1 each  bus source selects.
REQ-010 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select and control.
REQ-011 Read, write, IncPC  out  1 each  memory read, memory write, PC increment.

Function
REQ-012 States: RST, F0-F3, E0-E5, HALT. Outputs are a Moore decode of the registered state plus IR[31:27] and CON; every output not listed for a step is 0.
REQ-013 Transitions: RST->F0->F1->F2->F3->E0. After the last E step of a class, go to F0, or to HALT if Stop=1 in that cycle. HALT exits only by reset.
REQ-014 Fetch steps:
- F0: PCout, MARin, IncPC.
- F1: Read (synchronous RAM access cycle).
- F2: Read, MDRin.
- F3: MDRout, IRin.
REQ-015 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011. Codes 11100-11111 execute as nop.
REQ-016 Three-register ALU ops (add through shl):
- E0: Grb, Rout, Yin.
- E1: Grc, Rout, Zin.
- E2: ZLOout, Gra, Rin.
REQ-017 Immediate ops (addi, andi, ori): E0 Grb, Rout, Yin; E1 Cout, Zin; E2 ZLOout, Gra, Rin.
REQ-018 neg and not: E0 Grb, Rout, Zin; E1 ZLOout, Gra, Rin.
REQ-019 mul and div: E0 Gra, Rout, Yin; E1 Grb, Rout, Zin; E2 ZLOout, LOin; E3 ZHIout, HIin.
REQ-020 ldi: E0 Grb, BAout, Yin; E1 Cout, Zin; E2 ZLOout, Gra, Rin.
REQ-021 ld: E0-E1 as ldi; E2 ZLOout, MARin; E3 Read; E4 Read, MDRin; E5 MDRout, Gra, Rin.
REQ-022 st: E0-E2 as ld; E3 Gra, Rout, MDRin; E4 write.
REQ-023 br: E0 Gra, Rout, CONin; E1 PCout, Yin; E2 Cout, Zin; E3 ZLOout and PCin only if CON=1, otherwise no outputs.
REQ-024 jr: E0 Gra, Rout, PCin.
REQ-025 jal: E0 PCout, Grb, Rin; E1 Gra, Rout, PCin.
REQ-026 Single-step transfers: in (E0 INPORTout, Gra, Rin), out (E0 Gra, Rout, OUTPORTin), mfhi (E0 HIout, Gra, Rin), mflo (E0 LOout, Gra, Rin).
REQ-027 nop: E0 with no outputs. halt: E0 with no outputs, then HALT regardless of Stop.
REQ-028 Stop asserted mid-instruction has no effect until that instruction's last E step; at most one bus-source output is high in any state.

Reset
REQ-029 clr=0 forces state RST immediately, mid-instruction included, and drives every control output and Run to 0; no write pulse is permitted while clr=0.
REQ-030 The first rising edge with clr=1 moves RST->F0; Run=1 from F0 onward.

Structure
REQ-031 Shared package holds the opcode constants, the state encoding and the instruction-class enumeration.
REQ-032 Single sub-module: control_decode, which is combinational and maps state, opcode and CON to the output vector; the parent holds the state register and next-state logic.

Verification
REQ-033 Release reset with IR loaded with add r1,r2,r3 -> F0..F3 then E0 Grb/Rout/Yin, E1 Grc/Rout/Zin, E2 ZLOout/Gra/Rin; F0 follows on the 8th edge.
REQ-034 Execute st -> write high in E4 only, exactly one cycle; F0 follows.
REQ-035 Execute br with CON=0, then with CON=1 -> PCin low in E3 in the first case, ZLOout and PCin high in E3 in the second.
REQ-036 Execute mul with Stop pulsed during E1 -> LOin in E2, HIin in E3, then HALT with Run=0 and all outputs 0.
REQ-037 Drive clr low during ld E3 -> all outputs 0 immediately; after release, F0 with PCout, MARin, IncPC high.
REQ-038 Opcode 11110 -> a single idle E0, then F0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcode values, FSM state
// encodings, the instruction-class enumeration and the packed control vector.
// Helper functions map an opcode to its class and a class to its final
// execute step.
package control_unit_pkg;

  // Opcodes, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                         OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                         OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                         OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
                         OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                         OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
                         OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100,
                         OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                         OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010,
                         OP_HALT = 5'b11011;

  // State encoding; E0..E5 are consecutive so "next E step" is state + 1.
  localparam logic [3:0] S_RST  = 4'd0,
                         S_F0   = 4'd1, S_F1 = 4'd2, S_F2 = 4'd3, S_F3 = 4'd4,
                         S_E0   = 4'd5, S_E1 = 4'd6, S_E2 = 4'd7, S_E3 = 4'd8,
                         S_E4   = 4'd9, S_E5 = 4'd10,
                         S_HALT = 4'd11;

  typedef enum logic [3:0] {
    CLS_ALU3, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LDI, CLS_LD, CLS_ST,
    CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO,
    CLS_NOP, CLS_HALT
  } instr_class_t;

  typedef struct packed {
    logic hi_in, lo_in, pc_in, mdr_in, z_in, y_in, mar_in, ir_in, con_in, outport_in;
    logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic read, write, inc_pc;
  } ctrl_t;

  function automatic instr_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:       return CLS_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:      return CLS_IMM;
      OP_NEG, OP_NOT:                return CLS_UNARY;
      OP_MUL, OP_DIV:                return CLS_MULDIV;
      OP_LDI:                        return CLS_LDI;
      OP_LD:                         return CLS_LD;
      OP_ST:                         return CLS_ST;
      OP_BR:                         return CLS_BR;
      OP_JR:                         return CLS_JR;
      OP_JAL:                        return CLS_JAL;
      OP_IN:                         return CLS_IN;
      OP_OUT:                        return CLS_OUT;
      OP_MFHI:                       return CLS_MFHI;
      OP_MFLO:                       return CLS_MFLO;
      OP_HALT:                       return CLS_HALT;
      default:                       return CLS_NOP;  // nop and unused codes
    endcase
  endfunction

  function automatic logic [3:0] last_e_state(input instr_class_t cls);
    case (cls)
      CLS_ALU3, CLS_IMM, CLS_LDI:    return S_E2;
      CLS_UNARY, CLS_JAL:            return S_E1;
      CLS_MULDIV, CLS_BR:            return S_E3;
      CLS_LD:                        return S_E5;
      CLS_ST:                        return S_E4;
      default:                       return S_E0;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational Moore decode of the control-unit state.
// Ports:
//   state  - registered FSM state
//   opcode - IR[31:27]
//   con    - branch condition flag
//   ctrl   - full control-signal vector (all zero in RST, HALT and idle steps)
module control_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] state,
  input  logic [4:0] opcode,
  input  logic       con,
  output ctrl_t      ctrl
);

  instr_class_t cls;
  assign cls = op_class(opcode);

  always_comb begin
    // NOTE: default every output first so no path through the cases can infer a latch.
    ctrl = '0;
    case (state)
      S_F0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; end
      S_F1: ctrl.read = 1'b1;
      S_F2: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
      S_F3: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      S_E0, S_E1, S_E2, S_E3, S_E4, S_E5: begin
        case (cls)
          CLS_ALU3, CLS_IMM: begin
            case (state)
              S_E0: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              S_E1: begin
                // Second operand comes from Rc or from the sign-extended C field.
                if (cls == CLS_ALU3) begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; end
                else                 ctrl.c_out = 1'b1;
                ctrl.z_in = 1'b1;
              end
              S_E2: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          CLS_UNARY: begin
            case (state)
              S_E0: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
              S_E1: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          CLS_MULDIV: begin
            case (state)
              S_E0: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              S_E1: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
              S_E2: begin ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1; end
              S_E3: begin ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1; end
              default: ;
            endcase
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            // All three form the effective address Rb(or 0) + C in Z first.
            case (state)
              S_E0: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
              S_E1: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
              S_E2: begin
                ctrl.zlo_out = 1'b1;
                if (cls == CLS_LDI) begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                else                ctrl.mar_in = 1'b1;
              end
              S_E3: begin
                if (cls == CLS_LD) ctrl.read = 1'b1;
                else begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
              end
              S_E4: begin
                if (cls == CLS_LD) begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
                else               ctrl.write = 1'b1;
              end
              S_E5: begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          CLS_BR: begin
            case (state)
              S_E0: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
              S_E1: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
              S_E2: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
              S_E3: begin ctrl.zlo_out = con; ctrl.pc_in = con; end
              default: ;
            endcase
          end
          CLS_JR:
            if (state == S_E0) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
          CLS_JAL: begin
            case (state)
              S_E0: begin ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1; end
              S_E1: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
              default: ;
            endcase
          end
          CLS_IN:
            if (state == S_E0) begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CLS_OUT:
            if (state == S_E0) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
          CLS_MFHI:
            if (state == S_E0) begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          CLS_MFLO:
            if (state == S_E0) begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          default: ;  // nop, halt: idle E0
        endcase
      end
      default: ;  // RST, HALT
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: fetch/execute sequencer for the 32-bit CPU.
// Ports:
//   Clock, clr (async active-low reset), IR (opcode in IR[31:27]), CON, Stop
//   Run            - high in every state except RST and HALT
//   *in / *out     - register load enables and bus source selects
//   Gra..BAout     - register-file selects and control
//   Read/write/IncPC - memory strobes and PC increment
// A Stop request seen at any point during an instruction is held pending and
// acted on at that instruction's last execute step.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        Run,
  output logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
  output logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Read, write, IncPC
);

  logic [3:0]   state, state_next;
  logic         stop_pending;
  instr_class_t cls;
  ctrl_t        ctrl;
  logic         unused_ir_bits;

  assign cls            = op_class(IR[31:27]);
  assign unused_ir_bits = ^IR[26:0];

  always_comb begin
    state_next = S_RST;
    case (state)
      S_RST:  state_next = S_F0;
      S_F0:   state_next = S_F1;
      S_F1:   state_next = S_F2;
      S_F2:   state_next = S_F3;
      S_F3:   state_next = S_E0;
      S_E0, S_E1, S_E2, S_E3, S_E4, S_E5:
        if (state == last_e_state(cls))
          state_next = (cls == CLS_HALT || Stop || stop_pending) ? S_HALT : S_F0;
        else
          state_next = state + 4'd1;
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      state        <= S_RST;
      stop_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state <= state_next;
      if (state_next == S_F0) stop_pending <= 1'b0;
      else if (Stop)          stop_pending <= 1'b1;
    end
  end

  control_decode u_decode (
    .state  (state),
    .opcode (IR[31:27]),
    .con    (CON),
    .ctrl   (ctrl)
  );

  assign Run = (state != S_RST) && (state != S_HALT);

  assign HIin = ctrl.hi_in;   assign LOin = ctrl.lo_in;     assign PCin = ctrl.pc_in;
  assign MDRin = ctrl.mdr_in; assign Zin = ctrl.z_in;       assign Yin = ctrl.y_in;
  assign MARin = ctrl.mar_in; assign IRin = ctrl.ir_in;     assign CONin = ctrl.con_in;
  assign OUTPORTin = ctrl.outport_in;
  assign HIout = ctrl.hi_out; assign LOout = ctrl.lo_out;   assign ZHIout = ctrl.zhi_out;
  assign ZLOout = ctrl.zlo_out; assign PCout = ctrl.pc_out; assign MDRout = ctrl.mdr_out;
  assign INPORTout = ctrl.inport_out; assign Cout = ctrl.c_out;
  assign Gra = ctrl.gra;      assign Grb = ctrl.grb;        assign Grc = ctrl.grc;
  assign Rin = ctrl.r_in;     assign Rout = ctrl.r_out;     assign BAout = ctrl.ba_out;
  assign Read = ctrl.read;    assign write = ctrl.write;    assign IncPC = ctrl.inc_pc;

endmodule
